instr_fetch: RTL

Instruction fetch stage for the RV32I core. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched instruction, already sliced into opcode/funct3/funct7, to the control decoder and the datapath. On each retire it consumes the decoder's PCSel and the ALU-computed target to choose the next PC, which closes the fetch–decode–execute loop.

---
 rtl/instr_fetch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage. Owns the PC, runs the imem req/ack handshake, holds the fetched instruction and counts retires.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to trap on a retire whose next PC has bit 1 set.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSel,
    input  logic [31:0] alu_target,
    input  logic        inst_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret,
    output logic        trap
);

`ifdef IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        TRAP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;
`endif

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] inst_r;
    logic [31:0] inst_s;
    logic [31:0] instret_r;
    logic [31:0] instret_s;
    logic        req_r;
    logic        req_s;
    logic        valid_r;
    logic        valid_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] retire_pc_s;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        trap_r;
    logic        trap_s;
`endif

    // Branch/jump targets are JALR-style: bit 0 is always cleared.
    function automatic logic [31:0] next_pc_f(
        input logic        sel,
        input logic [31:0] tgt,
        input logic [31:0] seq
    );
        logic [31:0] res;
        if (sel) begin
            res = tgt & 32'hFFFF_FFFE;
        end else begin
            res = seq;
        end
        return res;
    endfunction

    assign pc_plus4_s  = pc_r + 32'd4;
    assign retire_pc_s = next_pc_f(PCSel, alu_target, pc_plus4_s);

    // Next-state, next-PC and handshake decisions for the fetch FSM.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        inst_s    = inst_r;
        instret_s = instret_r;
        req_s     = 1'b0;
        valid_s   = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        trap_s    = trap_r;
`endif
        case (state_r)
            IDLE: begin
                state_s = REQ;
                req_s   = 1'b1;
            end
            REQ: begin
                if (imem_ack) begin
                    inst_s  = imem_rdata;
                    valid_s = 1'b1;
                    state_s = HOLD;
                end else begin
                    req_s = 1'b1;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    instret_s = instret_r + 32'd1;
                    inst_s    = NOP_INST;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    // Faulting address is kept in pc so the handler can report it.
                    pc_s = retire_pc_s;
                    if (retire_pc_s[1]) begin
                        state_s = TRAP;
                        trap_s  = 1'b1;
                    end else begin
                        state_s = REQ;
                        req_s   = 1'b1;
                    end
`else
                    pc_s    = retire_pc_s & 32'hFFFF_FFFC;
                    state_s = REQ;
                    req_s   = 1'b1;
`endif
                end else begin
                    valid_s = 1'b1;
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            TRAP: begin
                state_s = TRAP;
                trap_s  = 1'b1;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any outstanding request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            inst_r    <= NOP_INST;
            instret_r <= 32'd0;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            inst_r    <= inst_s;
            instret_r <= instret_s;
            req_r     <= req_s;
            valid_r   <= valid_s;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_r <= 1'b0;
        end else begin
            trap_r <= trap_s;
        end
    end
    assign trap = trap_r;
`else
    assign trap = 1'b0;
`endif

    assign imem_req   = req_r;
    assign imem_addr  = pc_r;
    assign inst       = inst_r;
    assign opcode     = inst_r[6:0];
    assign funct3     = inst_r[14:12];
    assign funct7     = inst_r[31:25];
    assign inst_valid = valid_r;
    assign pc         = pc_r;
    assign pc_plus4   = pc_plus4_s;
    assign instret    = instret_r;

endmodule
